uart_rx_monitor: RTL and testbench

//   Bench-side UART receiver: the receiving end of the DUT's io_uart_tx line.

---
 rtl/uart_rx_monitor.sv | 158 +++++++++++++++
 tb/tb_uart_rx_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_monitor
// Brief    : 8N1 UART receiver with mid-bit sampling and a byte FIFO drained
//            through a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rxd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_full_bit = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_bit = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_ptr_w:0]   c_depth    = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic               r_sync1, r_sync2;
  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [7:0]         r_shreg, w_shreg_nxt;
  logic               r_frame_err;
  logic               w_push, w_frame_err, w_sample, w_rxs;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr, r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_overflow;
  logic               w_pop, w_push_ok;

  assign w_rxs    = r_sync2;
  assign w_sample = (r_bit_cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_idx       <= '0;
      r_shreg     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rxd;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shreg     <= w_shreg_nxt;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_idx_nxt     = r_idx;
    w_shreg_nxt   = r_shreg;
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt   = S_START;
          w_bit_cnt_nxt = c_half_bit;
        end
      end
      S_START: begin
        if (!w_sample) begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end else if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = c_full_bit;
          w_idx_nxt     = '0;
        end
      end
      S_DATA: begin
        if (!w_sample) begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end else begin
          w_shreg_nxt   = {w_rxs, r_shreg[7:1]};
          w_bit_cnt_nxt = c_full_bit;
          w_idx_nxt     = r_idx + 1'b1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (!w_sample) begin
          w_bit_cnt_nxt = r_bit_cnt - 1'b1;
        end else if (w_rxs) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_frame_err = 1'b1;
          w_state_nxt = S_BREAK;
        end
      end
      S_BREAK: begin
        // A line held low stays here so it reports only one framing error.
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_pop     = out_valid && out_ready;
  assign w_push_ok = w_push && ((r_count < c_depth) || w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= r_shreg;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push_ok) r_count <= r_count - 1'b1;
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rptr];
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_monitor
// Brief    : Directed, table-driven bench for uart_rx_monitor (8 clk/bit, 4-deep FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid, frame_err, overflow;
  logic [7:0] out_data;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  logic [7:0] popped [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic [7:0] head;
    int         count;
    int         fe;
    logic       ovf;
  } vec_t;

  vec_t vecs [6];

  uart_rx_monitor #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .rxd        (rxd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && frame_err) fe_cnt++;
    if (!reset && out_valid && out_ready) popped.push_back(out_data);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(8);
    end
    rxd = stop;
    tick(8);
    rxd = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxd = 1'b1;
    out_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    popped.delete();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick(10);
    out_ready = 1'b0;
    tick(1);
  endtask

  task automatic check_pops(input string nm);
    chk({nm, "_npop"}, popped.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_pop%0d", nm, i), (i < popped.size()) ? {24'd0, popped[i]} : 32'hFFFF_FFFF,
          {24'd0, exp_q[i]});
  endtask

  initial begin
    int fe_base;
    vecs[0] = '{tx: 8'h55, stop: 1'b1, head: 8'h55, count: 1, fe: 0, ovf: 1'b0};
    vecs[1] = '{tx: 8'h81, stop: 1'b1, head: 8'h55, count: 2, fe: 0, ovf: 1'b0};
    vecs[2] = '{tx: 8'h41, stop: 1'b0, head: 8'h55, count: 2, fe: 1, ovf: 1'b0};
    vecs[3] = '{tx: 8'h00, stop: 1'b1, head: 8'h55, count: 3, fe: 1, ovf: 1'b0};
    vecs[4] = '{tx: 8'hFF, stop: 1'b1, head: 8'h55, count: 4, fe: 1, ovf: 1'b0};
    vecs[5] = '{tx: 8'h12, stop: 1'b1, head: 8'h55, count: 4, fe: 1, ovf: 1'b1};

    // Reset state
    tick(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", fifo_count, 0);
    do_reset();

    // Table: frames received with out_ready low, ending in an overflow drop
    fe_base = fe_cnt;
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].tx, vecs[i].stop);
      tick(6);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_head", i), out_data, vecs[i].head);
      chk($sformatf("v%0d_count", i), fifo_count, vecs[i].count);
      chk($sformatf("v%0d_ferr", i), fe_cnt - fe_base, vecs[i].fe);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
    end
    drain();
    exp_q = '{8'h55, 8'h81, 8'h00, 8'hFF};
    check_pops("tbl");
    chk("tbl_count_end", fifo_count, 0);
    chk("tbl_ovf_sticky", overflow, 1);

    // Back-to-back frames, zero idle bits
    do_reset();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(6);
    chk("b2b_count", fifo_count, 3);
    drain();
    exp_q = '{8'hA3, 8'h00, 8'hFF};
    check_pops("b2b");
    chk("b2b_count_end", fifo_count, 0);

    // Short low glitch rejected in START
    do_reset();
    fe_base = fe_cnt;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(20);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_ferr", fe_cnt - fe_base, 0);

    // Stop bit low with line held low: one framing error, then recovery
    do_reset();
    fe_base = fe_cnt;
    send_frame(8'h41, 1'b0);
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(10);
    chk("brk_ferr", fe_cnt - fe_base, 1);
    chk("brk_count", fifo_count, 0);
    send_frame(8'h42, 1'b1);
    tick(6);
    chk("brk_count2", fifo_count, 1);
    chk("brk_data", out_data, 8'h42);
    chk("brk_ferr2", fe_cnt - fe_base, 1);

    // Full FIFO, pop in the exact push cycle of the fifth byte
    do_reset();
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    tick(6);
    chk("pp_count4", fifo_count, 4);
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(78);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
      end
    join
    tick(6);
    chk("pp_ovf", overflow, 0);
    chk("pp_count", fifo_count, 4);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_pops("pp");

    // Reset in the middle of DATA aborts the frame
    do_reset();
    fe_base = fe_cnt;
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      rxd = 8'h7E >> i;
      tick(8);
    end
    reset = 1'b1;
    tick(2);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", out_data, 0);
    rxd = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("mid_idle_count", fifo_count, 0);
    send_frame(8'h3C, 1'b1);
    tick(6);
    chk("mid_count", fifo_count, 1);
    chk("mid_data", out_data, 8'h3C);
    chk("mid_ferr", fe_cnt - fe_base, 0);
    chk("mid_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
